// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared constants and types for the L1 refill path and the block memory
//   arbiter.
//   PA_WIDTH   : physical byte address width
//   BLK_WIDTH  : cache block width in bits
//   WRD_WIDTH  : CPU word width in bits
//   BYTE       : bits per byte
//   OFFS_WIDTH : byte-offset bits inside one block
//   arb_state_t: arbiter FSM states
package cache_pkg;

  localparam int PA_WIDTH   = 16;
  localparam int BLK_WIDTH  = 512;
  localparam int WRD_WIDTH  = 32;
  localparam int BYTE       = 8;
  localparam int OFFS_WIDTH = $clog2(BLK_WIDTH / BYTE);
  localparam int BLK_BYTES  = BLK_WIDTH / BYTE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Force the byte-offset bits to zero so the access covers a whole block.
  function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] a);
    blk_align = {a[PA_WIDTH-1:OFFS_WIDTH], {OFFS_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Purely combinational two-way round-robin pick.
//   req[1:0]  : pending requests
//   prio      : requester that wins when both are pending
//   gnt_valid : at least one request is pending
//   gnt_id    : index of the winning requester
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  // Single requester wins outright; on a tie the priority holder wins.
  assign gnt_id    = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port block memory between requester 0 (I-cache refill)
//   and requester 1 (D-cache refill / write-back). One block transaction at a
//   time, round-robin selection, block-aligned addressing, fixed access
//   latency, one-cycle ack per transaction.
//
//   Parameters: LATENCY (BUSY cycles per access, 1..255), MEM_DEPTH (bytes),
//               RST_PRIO (requester holding priority after reset).
//   Optional:   MEM_ARB_STATS_EN adds gnt_cnt0/gnt_cnt1 (32-bit) and err_cnt
//               (16-bit) saturating counters.
//
//   Ports:
//     clk, rst                     clock, async active-high reset
//     req*/we*/addr*/wdata*        requester side, held until ack
//     ack0/ack1                    one-cycle completion pulses
//     rsp_data/rsp_err             response, valid while an ack is high
//     mem_addr/mem_rd_en/mem_wr_en/mem_wr_data/mem_rd_data   memory side
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; arbitrates and range-checks on grant
//   BUSY  | memory access in progress, cnt counts down to 0
//   RESP  | ack pulse high for the granted requester, priority rotates
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_DEPTH = 32768,
  parameter int RST_PRIO  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [PA_WIDTH-1:0]  addr0,
  input  logic [PA_WIDTH-1:0]  addr1,
  input  logic [BLK_WIDTH-1:0] wdata0,
  input  logic [BLK_WIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [BLK_WIDTH-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_data,
  input  logic [BLK_WIDTH-1:0] mem_rd_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]          gnt_cnt0,
  output logic [31:0]          gnt_cnt1,
  output logic [15:0]          err_cnt
`endif
);

  arb_state_t state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 prio_q, prio_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [PA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [BLK_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [BLK_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 gnt_valid;
  logic                 gnt_id;
  logic                 sel_we;
  logic [PA_WIDTH-1:0]  sel_addr;
  logic [PA_WIDTH-1:0]  aligned;
  logic [BLK_WIDTH-1:0] sel_wdata;
  logic [31:0]          blk_end;
  logic                 range_err;

  rr_arb2 u_rr_arb2 (
    .req       ({req1, req0}),
    .prio      (prio_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_we    = gnt_id ? we1    : we0;
  assign sel_addr  = gnt_id ? addr1  : addr0;
  assign sel_wdata = gnt_id ? wdata1 : wdata0;
  assign aligned   = blk_align(sel_addr);
  // Widened so the end-of-block sum cannot wrap at the address width.
  assign blk_end   = 32'(aligned) + 32'(BLK_BYTES);
  assign range_err = blk_end > 32'(MEM_DEPTH);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    we_d          = we_q;
    err_d         = err_q;
    prio_d        = prio_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rd_en_d       = rd_en_q;
    wr_en_d       = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d = gnt_id;
          we_d = sel_we;
          if (range_err) begin
            // Out-of-range block: answer immediately, memory is never touched.
            err_d      = 1'b1;
            state_d    = RESP;
            ack0_d     = ~gnt_id;
            ack1_d     = gnt_id;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            err_d      = 1'b0;
            cnt_d      = 8'(LATENCY - 1);
            state_d    = BUSY;
            mem_addr_d = aligned;
            if (sel_we) begin
              mem_wr_data_d = sel_wdata;
              // With a single BUSY cycle the write strobe lands immediately.
              wr_en_d       = (LATENCY == 1);
            end else begin
              rd_en_d = 1'b1;
            end
          end
        end
      end

      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d    = RESP;
          rd_en_d    = 1'b0;
          ack0_d     = ~id_q;
          ack1_d     = id_q;
          rsp_err_d  = err_q;
          rsp_data_d = we_q ? '0 : mem_rd_data;
        end else begin
          cnt_d = cnt_q - 8'd1;
          // Write strobe only in the last BUSY cycle so an abort never
          // leaves a partially committed block.
          if (we_q && (cnt_q == 8'd1)) wr_en_d = 1'b1;
        end
      end

      RESP: begin
        prio_d  = ~id_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      prio_q        <= RST_PRIO[0];
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      we_q          <= we_d;
      err_q         <= err_d;
      prio_q        <= prio_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rd_en_q       <= rd_en_d;
      wr_en_q       <= wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = mem_wr_data_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [31:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    err_cnt_d  = err_cnt_q;
    if (ack0_q && (gnt_cnt0_q != '1)) gnt_cnt0_d = gnt_cnt0_q + 32'd1;
    if (ack1_q && (gnt_cnt1_q != '1)) gnt_cnt1_d = gnt_cnt1_q + 32'd1;
    if ((ack0_q || ack1_q) && rsp_err_q && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (LATENCY = 4, BLK_WIDTH = 512) with a
//   behavioural 32 KiB block memory behind it. Memory byte i starts as
//   (i & 0xFF) ^ 0x3C. Build with MEM_ARB_STATS_EN to also exercise the
//   grant/error counters.
module tb_mem_arbiter;
  import cache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req0 = 1'b0, req1 = 1'b0;
  logic                 we0 = 1'b0, we1 = 1'b0;
  logic [PA_WIDTH-1:0]  addr0 = '0, addr1 = '0;
  logic [BLK_WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic                 ack0, ack1;
  logic [BLK_WIDTH-1:0] rsp_data;
  logic                 rsp_err;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en, mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_data;
  logic [BLK_WIDTH-1:0] mem_rd_data;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]          gnt_cnt0, gnt_cnt1;
  logic [15:0]          err_cnt;
`endif

  logic [7:0] mem_bytes [0:32767];

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.LATENCY(4), .MEM_DEPTH(32768), .RST_PRIO(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1),
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32768; i++) mem_bytes[i] <= 8'(i) ^ 8'h3C;
  end

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int k = 0; k < BLK_BYTES; k++)
        mem_bytes[int'(mem_addr[14:0]) + k] <= mem_wr_data[k*8 +: 8];
  end

  always_comb begin
    mem_rd_data = '0;
    for (int k = 0; k < BLK_BYTES; k++)
      mem_rd_data[k*8 +: 8] = mem_bytes[int'(mem_addr[14:0]) + k];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Initial contents of the block at aligned address a.
  function automatic logic [BLK_WIDTH-1:0] exp_blk(input logic [PA_WIDTH-1:0] a);
    logic [BLK_WIDTH-1:0] r;
    for (int k = 0; k < BLK_BYTES; k++) r[k*8 +: 8] = 8'(int'(a) + k) ^ 8'h3C;
    return r;
  endfunction

  // Caller sets up the request just after a rising edge; the next edge is
  // the accepting edge. Records ack cycle (1-based after accept), memory
  // strobe counts and the response, then drops the request on the ack edge.
  task automatic observe(input int who, output int ack_cyc, output int rd_cyc,
                         output int wr_cyc, output logic [BLK_WIDTH-1:0] data,
                         output logic err, output logic [PA_WIDTH-1:0] maddr);
    ack_cyc = -1; rd_cyc = 0; wr_cyc = 0; data = 'x; err = 1'bx; maddr = 'x;
    @(posedge clk);
    for (int n = 1; n <= 20 && ack_cyc < 0; n++) begin
      @(negedge clk);
      if (mem_rd_en) begin rd_cyc++; maddr = mem_addr; end
      if (mem_wr_en) begin wr_cyc++; maddr = mem_addr; end
      if ((who == 0 && ack0) || (who == 1 && ack1)) begin
        ack_cyc = n; data = rsp_data; err = rsp_err;
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL reset_ack got %b want 00", {ack0, ack1}); end
    n_cmp++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_err++; $display("FAIL reset_en got %b want 00", {mem_rd_en, mem_wr_en}); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wr_data !== '0) begin n_err++; $display("FAIL reset_mem_wr_data got %h want 0", mem_wr_data); end
    n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_align();
    int ac, rc, wc; logic [BLK_WIDTH-1:0] d; logic e; logic [PA_WIDTH-1:0] ma;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0047;
    observe(0, ac, rc, wc, d, e, ma);
    n_cmp++; if (ac !== 5) begin n_err++; $display("FAIL rd_ack_cycle got %0d want 5", ac); end
    n_cmp++; if (rc !== 4) begin n_err++; $display("FAIL rd_en_cycles got %0d want 4", rc); end
    n_cmp++; if (wc !== 0) begin n_err++; $display("FAIL rd_wr_en_cycles got %0d want 0", wc); end
    n_cmp++; if (ma !== 16'h0040) begin n_err++; $display("FAIL rd_mem_addr got %h want 0040", ma); end
    n_cmp++; if (d !== exp_blk(16'h0040)) begin n_err++; $display("FAIL rd_data got %h want %h", d, exp_blk(16'h0040)); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL rd_err got %b want 0", e); end
  endtask

  task automatic test_write_read();
    int ac, rc, wc; logic [BLK_WIDTH-1:0] d; logic e; logic [PA_WIDTH-1:0] ma;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = {64{8'hA5}};
    observe(1, ac, rc, wc, d, e, ma);
    n_cmp++; if (ac !== 5) begin n_err++; $display("FAIL wr_ack_cycle got %0d want 5", ac); end
    n_cmp++; if (wc !== 1) begin n_err++; $display("FAIL wr_en_cycles got %0d want 1", wc); end
    n_cmp++; if (rc !== 0) begin n_err++; $display("FAIL wr_rd_en_cycles got %0d want 0", rc); end
    n_cmp++; if (ma !== 16'h0100) begin n_err++; $display("FAIL wr_mem_addr got %h want 0100", ma); end
    n_cmp++; if (d !== '0) begin n_err++; $display("FAIL wr_rsp_data got %h want 0", d); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL wr_err got %b want 0", e); end
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0100;
    observe(1, ac, rc, wc, d, e, ma);
    n_cmp++; if (ac !== 5) begin n_err++; $display("FAIL rb_ack_cycle got %0d want 5", ac); end
    n_cmp++; if (d !== {64{8'hA5}}) begin n_err++; $display("FAIL rb_data got %h want a5 pattern", d); end
  endtask

  // Both requesters held high from the same edge; acks must alternate 0,1,...
  // starting at cycle 5 and spaced 6 cycles apart.
  task automatic test_contention(input int n_acks);
    int cyc; int got;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
    @(posedge clk);
    cyc = 0; got = 0;
    while (got < n_acks && cyc < 6 * n_acks + 20) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        n_cmp++;
        if ({ack1, ack0} !== ((got % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_err++; $display("FAIL cont_order ack%0d got %b want %b", got, {ack1, ack0}, (got % 2 == 0) ? 2'b01 : 2'b10);
        end
        n_cmp++;
        if (cyc !== 5 + 6 * got) begin
          n_err++; $display("FAIL cont_cycle ack%0d got %0d want %0d", got, cyc, 5 + 6 * got);
        end
        got++;
      end
    end
    n_cmp++;
    if (got !== n_acks) begin n_err++; $display("FAIL cont_timeout got %0d acks want %0d", got, n_acks); end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_range_err();
    int ac, rc, wc; logic [BLK_WIDTH-1:0] d; logic e; logic [PA_WIDTH-1:0] ma;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h7FC1;
    observe(0, ac, rc, wc, d, e, ma);
    n_cmp++; if (ac !== 5) begin n_err++; $display("FAIL edge_ack_cycle got %0d want 5", ac); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL edge_err got %b want 0", e); end
    n_cmp++; if (ma !== 16'h7FC0) begin n_err++; $display("FAIL edge_mem_addr got %h want 7fc0", ma); end
    n_cmp++; if (d !== exp_blk(16'h7FC0)) begin n_err++; $display("FAIL edge_data got %h want %h", d, exp_blk(16'h7FC0)); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h8000;
    observe(0, ac, rc, wc, d, e, ma);
    n_cmp++; if (ac !== 1) begin n_err++; $display("FAIL err_ack_cycle got %0d want 1", ac); end
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", e); end
    n_cmp++; if (d !== '0) begin n_err++; $display("FAIL err_data got %h want 0", d); end
    n_cmp++; if ({rc, wc} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL err_mem_en got rd=%0d wr=%0d want 0/0", rc, wc); end
  endtask

  task automatic test_reset_mid_write();
    int ac, rc, wc, acks, wrs; logic [BLK_WIDTH-1:0] d; logic e; logic [PA_WIDTH-1:0] ma;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = {64{8'h5A}};
    @(posedge clk);
    acks = 0; wrs = 0;
    @(negedge clk);
    if (ack0 || ack1) acks++;
    if (mem_wr_en) wrs++;
    n_cmp++; if (mem_wr_data !== {64{8'h5A}}) begin n_err++; $display("FAIL mid_pre_wr_data got %h want 5a pattern", mem_wr_data); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if ({ack0, ack1, mem_rd_en, mem_wr_en} !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ctrl got %b want 0000", {ack0, ack1, mem_rd_en, mem_wr_en}); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL mid_rst_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wr_data !== '0) begin n_err++; $display("FAIL mid_rst_wr_data got %h want 0", mem_wr_data); end
    req1 = 1'b0; we1 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack0 || ack1) acks++;
      if (mem_wr_en) wrs++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
      if (mem_wr_en) wrs++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL mid_no_ack got %0d want 0", acks); end
    n_cmp++; if (wrs !== 0) begin n_err++; $display("FAIL mid_no_write got %0d want 0", wrs); end
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0200;
    observe(0, ac, rc, wc, d, e, ma);
    n_cmp++; if (d !== exp_blk(16'h0200)) begin n_err++; $display("FAIL mid_block_unchanged got %h want %h", d, exp_blk(16'h0200)); end
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    int ac, rc, wc; logic [BLK_WIDTH-1:0] d; logic e; logic [PA_WIDTH-1:0] ma;
    do_reset();
    n_cmp++; if ({gnt_cnt0, gnt_cnt1, err_cnt} !== '0) begin n_err++; $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", gnt_cnt0, gnt_cnt1, err_cnt); end
    test_contention(10);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h8000;
    observe(0, ac, rc, wc, d, e, ma);
    n_cmp++; if (gnt_cnt0 !== 32'd6) begin n_err++; $display("FAIL stats_gnt0 got %0d want 6", gnt_cnt0); end
    n_cmp++; if (gnt_cnt1 !== 32'd5) begin n_err++; $display("FAIL stats_gnt1 got %0d want 5", gnt_cnt1); end
    n_cmp++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL stats_err got %0d want 1", err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_align();
    test_write_read();
    test_contention(4);
    test_range_err();
    test_reset_mid_write();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
